// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- stall/forward controller for the in-order MIPS pipeline.
//
// Sits beside the D-stage decoder. Each instruction leaving D is recorded
// in a shifting scoreboard (entry 1 = E ... entry DEPTH = last stage before
// writeback commit) holding {valid, dst, tnew}. A D-stage source register
// is compared against the scoreboard. The youngest matching writer decides
// whether D must stall (its result is not ready by the source's Tuse) or
// where the value can be forwarded from (its result is already produced).
// A multi-cycle multiply/divide busy counter stalls HI/LO users while the
// MD unit is computing.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   d_valid             D stage holds a real instruction
//   d_rs, d_rt          source register indices
//   d_tuse_rs/rt        Tuse per source; all-ones = source unused
//   d_we, d_dst, d_tnew GPR write enable, destination, Tnew at entry to E
//   d_md_start          mult/multu/div/divu
//   d_md_div            divide latency (with d_md_start)
//   d_md_use            reads/writes HI/LO or starts the MD unit
//   stall               freeze F/D, insert bubble into E
//   fwd_rs_sel/rt_sel   0 = register file, k = scoreboard entry k
//   md_busy             MD unit computing
module hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int DEPTH    = 3,
  parameter int T_BITS   = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int SEL_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                d_valid,
  input  logic [REG_BITS-1:0] d_rs,
  input  logic [REG_BITS-1:0] d_rt,
  input  logic [T_BITS-1:0]   d_tuse_rs,
  input  logic [T_BITS-1:0]   d_tuse_rt,
  input  logic                d_we,
  input  logic [REG_BITS-1:0] d_dst,
  input  logic [T_BITS-1:0]   d_tnew,
  input  logic                d_md_start,
  input  logic                d_md_div,
  input  logic                d_md_use,
  output logic                stall,
  output logic [SEL_BITS-1:0] fwd_rs_sel,
  output logic [SEL_BITS-1:0] fwd_rt_sel,
  output logic                md_busy
);

  localparam logic [T_BITS-1:0] T_NONE = {T_BITS{1'b1}};
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic                sb_vld  [1:DEPTH];
  logic [REG_BITS-1:0] sb_dst  [1:DEPTH];
  logic [T_BITS-1:0]   sb_tnew [1:DEPTH];
  logic [CNT_W-1:0]    md_cnt;

  logic                rs_hit, rt_hit;
  logic [SEL_BITS-1:0] rs_k, rt_k;
  logic [T_BITS-1:0]   rs_t, rt_t;
  logic                rs_haz, rt_haz;
  logic                md_go;

  // Tnew counts down one per stage and never wraps below zero.
  function automatic logic [T_BITS-1:0] sat_dec(input logic [T_BITS-1:0] t);
    return (t == '0) ? t : t - T_BITS'(1);
  endfunction

  // Youngest-match search: scanning oldest to youngest lets the lowest k
  // overwrite older hits, so older writers of the same register are shadowed.
  always_comb begin
    rs_hit = 1'b0;
    rs_k   = '0;
    rs_t   = '0;
    rt_hit = 1'b0;
    rt_k   = '0;
    rt_t   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (sb_vld[k] && (sb_dst[k] == d_rs) && (d_rs != '0)) begin
        rs_hit = 1'b1;
        rs_k   = SEL_BITS'(k);
        rs_t   = sb_tnew[k];
      end
      if (sb_vld[k] && (sb_dst[k] == d_rt) && (d_rt != '0)) begin
        rt_hit = 1'b1;
        rt_k   = SEL_BITS'(k);
        rt_t   = sb_tnew[k];
      end
    end
  end

  assign rs_haz     = rs_hit && (d_tuse_rs != T_NONE) && (rs_t > d_tuse_rs);
  assign rt_haz     = rt_hit && (d_tuse_rt != T_NONE) && (rt_t > d_tuse_rt);
  assign fwd_rs_sel = (rs_hit && (rs_t == '0)) ? rs_k : '0;
  assign fwd_rt_sel = (rt_hit && (rt_t == '0)) ? rt_k : '0;
  assign md_busy    = (md_cnt != '0);
  assign stall      = d_valid & (rs_haz | rt_haz | (d_md_use & md_busy));
  // A start while busy is impossible: d_md_start implies d_md_use, which stalls.
  assign md_go      = d_valid & d_md_start & ~stall;

  // D -> E boundary: scoreboard shift and MD countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb_vld[k]  <= 1'b0;
        sb_dst[k]  <= '0;
        sb_tnew[k] <= '0;
      end
      md_cnt <= '0;
    end else begin
      for (int k = 2; k <= DEPTH; k++) begin
        sb_vld[k]  <= sb_vld[k-1];
        sb_dst[k]  <= sb_dst[k-1];
        sb_tnew[k] <= sat_dec(sb_tnew[k-1]);
      end
      sb_vld[1]  <= ~stall & d_valid & d_we & (d_dst != '0);
      sb_dst[1]  <= stall ? '0 : d_dst;
      sb_tnew[1] <= stall ? '0 : d_tnew;
      if (md_go)
        md_cnt <= d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed instruction sequences, a behavioural
// model of the in-flight writer history and MD busy window, a per-cycle
// compare process and a few literal expectations.
module tb_hazard_ctrl;
  localparam int REG_BITS = 5;
  localparam int DEPTH    = 3;
  localparam int T_BITS   = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int SEL_BITS = 2;
  localparam int T_NONE   = (1 << T_BITS) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d_valid = 1'b0;
  logic [REG_BITS-1:0] d_rs = '0, d_rt = '0, d_dst = '0;
  logic [T_BITS-1:0] d_tuse_rs = '1, d_tuse_rt = '1, d_tnew = '0;
  logic d_we = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
  logic stall, md_busy;
  logic [SEL_BITS-1:0] fwd_rs_sel, fwd_rt_sel;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_BITS(REG_BITS), .DEPTH(DEPTH), .T_BITS(T_BITS),
                .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .SEL_BITS(SEL_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_dst(d_dst),
    .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use), .stall(stall), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy));

  always #5 clk = ~clk;

  // Model: the instructions that left D over the last DEPTH edges, with the
  // Tnew they carried into E; age in the pipe gives the current Tnew.
  bit m_v   [1:DEPTH] = '{default: 1'b0};
  int m_dst [1:DEPTH] = '{default: 0};
  int m_tn  [1:DEPTH] = '{default: 0};
  int cyc = 0;
  int busy_end = 0;

  function automatic int cur_tnew(int k);
    return (m_tn[k] > k - 1) ? m_tn[k] - (k - 1) : 0;
  endfunction

  function automatic int youngest(int r);
    for (int k = 1; k <= DEPTH; k++)
      if (r != 0 && m_v[k] && m_dst[k] == r) return k;
    return 0;
  endfunction

  function automatic int m_fwd(int r);
    int k;
    k = youngest(r);
    if (k == 0) return 0;
    return (cur_tnew(k) == 0) ? k : 0;
  endfunction

  function automatic bit m_haz(int r, int tuse);
    int k;
    k = youngest(r);
    if (k == 0 || tuse == T_NONE) return 1'b0;
    return cur_tnew(k) > tuse;
  endfunction

  function automatic bit m_busy();
    return cyc < busy_end;
  endfunction

  function automatic bit m_stall();
    return d_valid && (m_haz(int'(d_rs), int'(d_tuse_rs)) ||
                       m_haz(int'(d_rt), int'(d_tuse_rt)) ||
                       (d_md_use && m_busy()));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        m_v[k] = 1'b0; m_dst[k] = 0; m_tn[k] = 0;
      end
      busy_end = 0;
    end else begin
      bit s;
      s = m_stall();
      for (int k = DEPTH; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_dst[k] = m_dst[k-1]; m_tn[k] = m_tn[k-1];
      end
      m_v[1]   = !s && d_valid && d_we && d_dst != 0;
      m_dst[1] = int'(d_dst);
      m_tn[1]  = int'(d_tnew);
      cyc = cyc + 1;
      if (d_valid && d_md_start && !s)
        busy_end = cyc + (d_md_div ? DIV_LAT : MULT_LAT);
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("stall", 8'(stall), 8'(m_stall()));
    check("fwd_rs_sel", 8'(fwd_rs_sel), 8'(m_fwd(int'(d_rs))));
    check("fwd_rt_sel", 8'(fwd_rt_sel), 8'(m_fwd(int'(d_rt))));
    check("md_busy", 8'(md_busy), 8'(m_busy()));
  end

  task automatic put(input bit v, input int rs, input int rt, input int tus,
                     input int tut, input bit we, input int dst, input int tnew,
                     input bit mds, input bit mdd, input bit mdu);
    d_valid = v; d_rs = REG_BITS'(rs); d_rt = REG_BITS'(rt);
    d_tuse_rs = T_BITS'(tus); d_tuse_rt = T_BITS'(tut);
    d_we = we; d_dst = REG_BITS'(dst); d_tnew = T_BITS'(tnew);
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
  endtask

  task automatic idle();
    put(0, 0, 0, T_NONE, T_NONE, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic flush();
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  initial begin
    int n;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("reset_stall", 8'(stall), 8'd0);
    check("reset_md_busy", 8'(md_busy), 8'd0);
    check("reset_fwd", 8'(fwd_rs_sel), 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    flush();

    // lw $8 (tnew 2) then add using $8 (tuse 1)
    put(1, 29, 0, 1, T_NONE, 1, 8, 2, 0, 0, 0); #1;
    check("lw_nostall", 8'(stall), 8'd0);
    tick();
    put(1, 8, 0, 1, 1, 1, 10, 1, 0, 0, 0); #1;
    check("lw_use_stall", 8'(stall), 8'd1);
    tick(); #1;
    check("lw_use_release", 8'(stall), 8'd0);
    check("lw_use_fwd_e2", 8'(fwd_rs_sel), 8'd0);
    tick();
    put(1, 8, 0, 1, T_NONE, 0, 0, 0, 0, 0, 0); #1;
    check("lw_fwd_e3", 8'(fwd_rs_sel), 8'd3);
    tick();
    flush();

    // ori $9 (tnew 1) then beq on $9 (tuse 0)
    put(1, 0, 0, 1, T_NONE, 1, 9, 1, 0, 0, 0);
    tick();
    put(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("beq_stall", 8'(stall), 8'd1);
    tick(); #1;
    check("beq_release", 8'(stall), 8'd0);
    check("beq_fwd_e2", 8'(fwd_rs_sel), 8'd2);
    tick();
    flush();

    // two writers of $5, youngest wins
    put(1, 0, 0, T_NONE, T_NONE, 1, 5, 0, 0, 0, 0);
    tick();
    put(1, 0, 0, T_NONE, T_NONE, 1, 5, 0, 0, 0, 0);
    tick();
    put(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0); #1;
    check("shadow_fwd_rs", 8'(fwd_rs_sel), 8'd1);
    check("shadow_fwd_rt", 8'(fwd_rt_sel), 8'd1);
    tick();
    flush();

    // writes to $0 are never tracked
    put(1, 0, 0, T_NONE, T_NONE, 1, 0, 2, 0, 0, 0);
    tick();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("zero_reg_stall", 8'(stall), 8'd0);
    check("zero_reg_fwd", 8'(fwd_rs_sel), 8'd0);
    tick();
    // forwarding select ignores d_valid
    put(1, 0, 0, T_NONE, T_NONE, 1, 7, 0, 0, 0, 0);
    tick();
    put(0, 7, 0, 0, T_NONE, 0, 0, 0, 0, 0, 0); #1;
    check("fwd_no_valid", 8'(fwd_rs_sel), 8'd1);
    tick();
    flush();

    // mult then mfhi: five stall cycles
    put(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); #1;
    check("mult_accept", 8'(stall), 8'd0);
    tick();
    put(1, 0, 0, T_NONE, T_NONE, 1, 2, 1, 0, 0, 1); #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      tick(); #1;
    end
    check("mult_stall_len", 8'(n), 8'd5);
    check("mfhi_busy_done", 8'(md_busy), 8'd0);
    tick();
    flush();

    // div, reset pulsed on busy cycle 3
    put(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    tick();
    put(1, 0, 0, T_NONE, T_NONE, 1, 3, 1, 0, 0, 1);
    tick(); tick(); #1;
    check("div_busy_c3", 8'(md_busy), 8'd1);
    check("div_stall_c3", 8'(stall), 8'd1);
    rst_n = 1'b0; #1;
    check("rst_md_busy", 8'(md_busy), 8'd0);
    check("rst_stall", 8'(stall), 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    check("post_rst_stall", 8'(stall), 8'd0);
    tick(); #1;
    check("mflo_passes", 8'(stall), 8'd0);
    check("mflo_busy", 8'(md_busy), 8'd0);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised stall/forward controller for the in-order MIPS pipeline; sits beside the D-stage decoder.
- Consumes per-instruction Tuse/Tnew from the decoder and tracks in-flight register writers in a shifting scoreboard, one entry per post-D stage.
- Drives the global stall and the D-stage forwarding selects.
- Owns a multi-cycle multiply/divide busy counter and stalls HI/LO users while it runs.

Parameters:
- REG_BITS, 5, register index width.
- DEPTH, 3, tracked post-D stages (entry 1 = E ... entry DEPTH = last stage before writeback commit).
- T_BITS, 2, width of Tuse/Tnew fields.
- MULT_LAT, 5, busy cycles for mult/multu.
- DIV_LAT, 10, busy cycles for div/divu.
- SEL_BITS, 2, forwarding-select width; must hold 0..DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- d_valid  in  1  D stage holds a real instruction.
- d_rs  in  REG_BITS  rs index.
- d_rt  in  REG_BITS  rt index.
- d_tuse_rs  in  T_BITS  Tuse of rs; all-ones = rs unused.
- d_tuse_rt  in  T_BITS  Tuse of rt; all-ones = rt unused.
- d_we  in  1  instruction writes a GPR.
- d_dst  in  REG_BITS  destination GPR.
- d_tnew  in  T_BITS  Tnew at entry to E.
- d_md_start  in  1  instruction is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: divide latency.
- d_md_use  in  1  instruction reads or writes HI/LO or starts the MD unit.
- stall  out  1  freeze F/D, insert bubble into E.
- fwd_rs_sel  out  SEL_BITS  0 = register file, k = entry k.
- fwd_rt_sel  out  SEL_BITS  as fwd_rs_sel, for rt.
- md_busy  out  1  MD unit computing.

Behaviour:
- Scoreboard entry fields: valid, dst, tnew.
- Reset (async, rst_n=0): all entries invalid, tnew=0, MD counter=0.
  - stall, fwd_*_sel and md_busy are all 0 while reset is held and in the first cycle after release.
- Each rising edge, entry k+1 <= entry k, with tnew saturating-decremented (0 stays 0). The entry DEPTH contents are discarded.
- Entry 1 load at each rising edge:
  - !stall: load {d_valid & d_we & d_dst!=0, d_dst, d_tnew}.
  - stall: load an invalid entry (bubble).
- Match for a source reg r (rs or rt): valid entry k with dst==r and r!=0.
  - Only the youngest (lowest k) match counts; older matches are shadowed.
- Data-hazard stall for a source: youngest match exists, Tuse != all-ones, and entry tnew > Tuse.
- Forwarding select:
  - fwd_x_sel = k if the youngest match has tnew==0; otherwise 0.
  - fwd_x_sel is 0 when the register is $0.
  - fwd_x_sel is independent of d_valid and of stall.
- MD counter:
  - Loads MULT_LAT, or DIV_LAT when d_md_div=1, on a rising edge where d_valid & d_md_start & !stall.
  - Otherwise decrements toward 0.
  - md_busy = (counter != 0); first high cycle is the one after the start edge.
- stall = d_valid & (rs hazard | rt hazard | (d_md_use & md_busy)).
- Combinational paths: stall and fwd_*_sel are combinational from D inputs and registered state; no combinational path through clk.
- A start is never accepted while busy: a start implies d_md_use, so it stalls.
- Mid-operation reset clears everything immediately, including an MD countdown in progress.

Test Plan:
- lw $8 (d_tnew=2), then add using $8 (tuse 1): one stall cycle. Next cycle entry 2 tnew=1 ≤ 1, stall=0. One cycle later entry 3 tnew=0 and fwd_rs_sel=3.
- ori $9 (tnew 1), then beq on $9 (tuse_rs 0): stall 1 cycle. Next cycle fwd_rs_sel=2, stall=0.
- Writers to $5 in entries 1 (tnew 0) and 2 (tnew 0), consumer of $5: fwd_rs_sel=1, the youngest match.
- Write to $0 with tnew 2, consumer of $0: no stall, fwd sel 0.
- mult accepted (MULT_LAT=5), then mfhi: md_busy high 5 cycles, stall high exactly 5 cycles, mfhi proceeds on the 6th.
- div accepted, rst_n pulsed low on busy cycle 3: md_busy=0, entries cleared, stall=0 immediately. A following mflo passes without stalling.
